// File: rtl/vga_timing_generator.sv
// VGA raster timing generator with a pixel-source handshake.
// Counts the raster, presents coordinates to the pixel source, delays sync and
// blanking flags by the source latency, and registers the adapter outputs.
// PIXEL_LATENCY must lie in 1..8; H_TOTAL and V_TOTAL must not exceed 1024.
module vga_timing_generator #(
  parameter int unsigned H_VISIBLE     = 640,
  parameter int unsigned H_FRONT       = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BACK        = 48,
  parameter int unsigned V_VISIBLE     = 480,
  parameter int unsigned V_FRONT       = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BACK        = 33,
  parameter bit          HSYNC_POL     = 1'b0,
  parameter bit          VSYNC_POL     = 1'b0,
  parameter int unsigned PIXEL_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] pixel_r,
  input  logic [3:0] pixel_g,
  input  logic [3:0] pixel_b,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_req,
  output logic       line_start,
  output logic       frame_start,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       horizontal_sync,
  output logic       vertical_sync,
  output logic       video_output
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Thresholds are 11 bits so a sync ending exactly at 1024 still compares correctly.
  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END    = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam int unsigned LAST_STAGE   = PIXEL_LATENCY - 1;

  // Raster counters and running flag
  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       run_q, run_d;

  // Stage-0 flags derived from the counters
  logic       vid0, hs0, vs0;
  logic       at_origin;
  logic [10:0] h_ext, v_ext;

  // Flag delay line, one bit per stage
  logic [PIXEL_LATENCY-1:0] vid_pipe_q, vid_pipe_d;
  logic [PIXEL_LATENCY-1:0] hs_pipe_q,  hs_pipe_d;
  logic [PIXEL_LATENCY-1:0] vs_pipe_q,  vs_pipe_d;

  // Adapter output registers
  logic [3:0] r_q, r_d;
  logic [3:0] g_q, g_d;
  logic [3:0] b_q, b_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_q, video_d;

  // Counter advance: clear while disabled, hold at origin for the first running cycle
  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    run_d = enable;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (run_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d = '0;
        end else begin
          v_d = v_q + 10'd1;
        end
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  // Stage-0 video, sync and handshake flags
  always_comb begin
    h_ext     = {1'b0, h_q};
    v_ext     = {1'b0, v_q};
    at_origin = (h_q == '0);
    vid0      = run_q && (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
    hs0       = run_q && (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
    vs0       = run_q && (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);
  end

  // Shift the flags along the delay line so they meet the returned pixel
  always_comb begin
    vid_pipe_d    = vid_pipe_q;
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;
    vid_pipe_d[0] = vid0;
    hs_pipe_d[0]  = hs0;
    vs_pipe_d[0]  = vs0;
    for (int unsigned i = 1; i < PIXEL_LATENCY; i++) begin
      vid_pipe_d[i] = vid_pipe_q[i-1];
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
    end
  end

  // Output stage: gate colour with delayed video, map syncs to their polarity
  always_comb begin
    video_d = vid_pipe_q[LAST_STAGE];
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (vid_pipe_q[LAST_STAGE]) begin
      r_d = pixel_r;
      g_d = pixel_g;
      b_d = pixel_b;
    end
    hsync_d = hs_pipe_q[LAST_STAGE] ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = vs_pipe_q[LAST_STAGE] ? VSYNC_POL : ~VSYNC_POL;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q        <= '0;
      v_q        <= '0;
      run_q      <= 1'b0;
      vid_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      hsync_q    <= ~HSYNC_POL;
      vsync_q    <= ~VSYNC_POL;
      video_q    <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      run_q      <= run_d;
      vid_pipe_q <= vid_pipe_d;
      hs_pipe_q  <= hs_pipe_d;
      vs_pipe_q  <= vs_pipe_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_q    <= video_d;
    end
  end

  assign pixel_x         = h_q;
  assign pixel_y         = v_q;
  assign pixel_req       = vid0;
  assign line_start      = run_q && at_origin;
  assign frame_start     = run_q && at_origin && (v_q == '0);
  assign r               = r_q;
  assign g               = g_q;
  assign b               = b_q;
  assign horizontal_sync = hsync_q;
  assign vertical_sync   = vsync_q;
  assign video_output    = video_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench for vga_timing_generator on a reduced raster (30x15).
module tb_vga_timing_generator;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int LAT = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst_n, enable;
  logic [3:0] pixel_r, pixel_g, pixel_b;
  logic [9:0] pixel_x, pixel_y;
  logic       pixel_req, line_start, frame_start;
  logic [3:0] r, g, b;
  logic       horizontal_sync, vertical_sync, video_output;

  vga_timing_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIXEL_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_req(pixel_req),
    .line_start(line_start), .frame_start(frame_start),
    .r(r), .g(g), .b(b),
    .horizontal_sync(horizontal_sync), .vertical_sync(vertical_sync),
    .video_output(video_output)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vid;
    logic       hs;
    logic       vs;
    logic [3:0] er;
    logic [3:0] eg;
    logic [3:0] eb;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] src[$];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mh, mv, mode;
  bit mrun;

  bit   meas_en;
  int   last_ls, last_fs, x0_cyc, xs_cyc, vs_cyc, hs_len, vs_len, vid_cnt;
  logic prev_hs, prev_vs, prev_vo;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pixel source content: 0 = coordinate pattern, 1 = constant 0xA, 2 = constant 0xF
  function automatic logic [11:0] colour(input int x, input int y, input int md);
    if (md == 1) return 12'hAAA;
    if (md == 2) return 12'hFFF;
    return {4'(x), 4'(y), 4'(x ^ y)};
  endfunction

  task automatic meas_clear();
    last_ls = -1; last_fs = -1; x0_cyc = -1; xs_cyc = -1; vs_cyc = -1;
    hs_len = 0; vs_len = 0; vid_cnt = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_vo = 1'b0;
  endtask

  task automatic measure();
    if (line_start) begin
      if (last_ls >= 0) check("ls_period", cyc - last_ls, HT);
      last_ls = cyc;
    end
    if (frame_start) begin
      if (last_fs >= 0) begin
        check("fs_period", cyc - last_fs, HT * VT);
        check("vid_per_frame", vid_cnt, HV * VV);
      end
      last_fs = cyc;
      vid_cnt = 0;
    end
    if (video_output) vid_cnt++;
    if (mrun && mh == 0 && mv < VV) x0_cyc = cyc;
    if (mrun && mh == HV + HF) xs_cyc = cyc;
    if (mrun && mh == 0 && mv == VV + VF) vs_cyc = cyc;
    if (!prev_vo && video_output && x0_cyc >= 0) check("vid_onset", cyc - x0_cyc, LAT + 1);
    if (prev_hs && !horizontal_sync && xs_cyc >= 0) check("hs_onset", cyc - xs_cyc, LAT + 1);
    if (prev_vs && !vertical_sync && vs_cyc >= 0) check("vs_onset", cyc - vs_cyc, LAT + 1);
    if (!horizontal_sync) hs_len++;
    else if (hs_len > 0) begin
      check("hs_width", hs_len, HS);
      hs_len = 0;
    end
    if (!vertical_sync) vs_len++;
    else if (vs_len > 0) begin
      check("vs_width", vs_len, HT * VS);
      vs_len = 0;
    end
    prev_hs = horizontal_sync;
    prev_vs = vertical_sync;
    prev_vo = video_output;
  endtask

  // One clock: update the raster model, feed the source, check the DUT
  task automatic step();
    logic        en_e, rst_e;
    logic [11:0] c;
    exp_t        e, o;
    bit          e_req, e_ls, e_fs;
    @(posedge clk);
    en_e = enable;
    rst_e = rst_n;
    #1;
    cyc++;
    if (!rst_e) begin
      mh = 0; mv = 0; mrun = 1'b0;
    end else begin
      if (!en_e) begin
        mh = 0; mv = 0;
      end else if (mrun) begin
        if (mh == HT - 1) begin
          mh = 0;
          mv = (mv == VT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
      mrun = en_e;
    end

    src.push_back(colour(int'(pixel_x), int'(pixel_y), mode));
    if (src.size() > LAT) begin
      c = src.pop_front();
      {pixel_r, pixel_g, pixel_b} = c;
    end

    if (!rst_n) begin
      check("rst_r", 32'(r), 0);
      check("rst_g", 32'(g), 0);
      check("rst_b", 32'(b), 0);
      check("rst_vo", 32'(video_output), 0);
      check("rst_hsync", 32'(horizontal_sync), 1);
      check("rst_vsync", 32'(vertical_sync), 1);
      check("rst_x", 32'(pixel_x), 0);
      check("rst_y", 32'(pixel_y), 0);
      check("rst_req", 32'(pixel_req), 0);
      check("rst_ls", 32'(line_start), 0);
      check("rst_fs", 32'(frame_start), 0);
      sb.delete();
      repeat (LAT + 1) sb.push_back('0);
    end else begin
      e_req = mrun && mh < HV && mv < VV;
      e_ls  = mrun && mh == 0;
      e_fs  = e_ls && mv == 0;
      check("x", 32'(pixel_x), mh);
      check("y", 32'(pixel_y), mv);
      check("req", 32'(pixel_req), 32'(e_req));
      check("ls", 32'(line_start), 32'(e_ls));
      check("fs", 32'(frame_start), 32'(e_fs));
      e.vid = e_req;
      e.hs  = mrun && mh >= HV + HF && mh < HV + HF + HS;
      e.vs  = mrun && mv >= VV + VF && mv < VV + VF + VS;
      {e.er, e.eg, e.eb} = e_req ? colour(mh, mv, mode) : 12'h000;
      sb.push_back(e);
      if (sb.size() > LAT + 1) begin
        o = sb.pop_front();
        check("vo", 32'(video_output), 32'(o.vid));
        check("r", 32'(r), 32'(o.er));
        check("g", 32'(g), 32'(o.eg));
        check("b", 32'(b), 32'(o.eb));
        check("hsync", 32'(horizontal_sync), o.hs ? 0 : 1);
        check("vsync", 32'(vertical_sync), o.vs ? 0 : 1);
      end
      if (meas_en) measure();
    end
  endtask

  task automatic wait_xy(input int x, input int y);
    int n = 0;
    while (!(mrun && mh == x && mv == y) && n < 2 * HT * VT) begin
      step();
      n++;
    end
    check("wait_x", 32'(pixel_x), x);
    check("wait_y", 32'(pixel_y), y);
  endtask

  initial begin
    rst_n = 1'b1;
    enable = 1'b0;
    mode = 2;
    pixel_r = 4'hF; pixel_g = 4'hF; pixel_b = 4'hF;
    mh = 0; mv = 0; mrun = 1'b0;
    meas_en = 1'b0;
    meas_clear();
    #2 rst_n = 1'b0;
    repeat (5) step();

    // Release with enable high: raster starts at the origin
    mode = 0;
    meas_clear();
    meas_en = 1'b1;
    enable = 1'b1;
    rst_n = 1'b1;
    step();
    check("first_fs", 32'(frame_start), 1);
    check("first_x", 32'(pixel_x), 0);
    repeat (2 * HT * VT) step();

    // Constant colour: only visible while video is active
    mode = 1;
    repeat (2 * HT * VT) step();

    // Drop enable inside the visible area
    wait_xy(10, 3);
    meas_en = 1'b0;
    enable = 1'b0;
    repeat (LAT + 1) step();
    check("en_off_vo_hold", 32'(video_output), 1);
    step();
    check("en_off_vo", 32'(video_output), 0);
    check("en_off_r", 32'(r), 0);
    check("en_off_hsync", 32'(horizontal_sync), 1);
    check("en_off_req", 32'(pixel_req), 0);
    check("en_off_x", 32'(pixel_x), 0);
    repeat (10) step();

    // Re-enable, then assert reset mid-frame
    enable = 1'b1;
    mode = 0;
    wait_xy(12, 5);
    check("pre_rst_vo", 32'(video_output), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_vo", 32'(video_output), 0);
    check("async_rst_r", 32'(r), 0);
    check("async_rst_x", 32'(pixel_x), 0);
    check("async_rst_y", 32'(pixel_y), 0);
    check("async_rst_hsync", 32'(horizontal_sync), 1);
    repeat (4) step();

    meas_clear();
    meas_en = 1'b1;
    rst_n = 1'b1;
    step();
    check("restart_fs", 32'(frame_start), 1);
    check("restart_y", 32'(pixel_y), 0);
    repeat (HT * VT + HT) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
